// File: rtl/wca_reg_bank_arbiter_pkg.sv
// Shared types and helpers for the config register bank arbiter.
// Holds the FSM encoding, the register width and a flat-bus slicing helper.
package wca_reg_bank_arbiter_pkg;

    localparam int REG_W    = 16;
    localparam int MAX_NREQ = 8;
    localparam int BUS_W    = MAX_NREQ * REG_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Field idx of width w from a flat per-requester bus (zero-extended to BUS_W).
    function automatic logic [REG_W-1:0] bus_slice(input logic [BUS_W-1:0] bus,
                                                   input int unsigned idx,
                                                   input int unsigned w);
        logic [BUS_W-1:0] sh_s;
        logic [REG_W-1:0] mask_s;
        sh_s   = bus >> (idx * w);
        mask_s = REG_W'((32'd1 << w) - 32'd1);
        return sh_s[REG_W-1:0] & mask_s;
    endfunction

endpackage

// File: rtl/wca_reg_bank_arbiter_if.sv
// Shared write bus between the requesters and the register bank arbiter.
interface wca_reg_bank_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   wr_addr;
    logic [NREQ*16-1:0]   wr_data;
    logic [NREQ-1:0]      gnt;
    logic                 addr_err;

    modport master (output req, output wr_addr, output wr_data, input gnt, input addr_err);
    modport slave  (input req, input wr_addr, input wr_data, output gnt, output addr_err);
endinterface

// File: rtl/wca_reg16_core.sv
// Existing 16-bit register core: synchronous clear with priority over enable.
module wca_reg16_core
    import wca_reg_bank_arbiter_pkg::*;
(
    input  logic             Clock,
    input  logic             Aclr,
    input  logic             Enable,
    input  logic [REG_W-1:0] D,
    output logic [REG_W-1:0] Q
);
    logic [REG_W-1:0] q_r;

    // Storage: clear wins over load.
    always_ff @(posedge Clock) begin
        if (Aclr) begin
            q_r <= '0;
        end else if (Enable) begin
            q_r <= D;
        end else begin
            q_r <= q_r;
        end
    end

    assign Q = q_r;
endmodule

// File: rtl/wca_reg_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts at ptr and wraps modulo NREQ.
module wca_rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_vld
);
    // First asserted request at or after the pointer wins.
    always_comb begin
        int  j;
        logic hit_s;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j         = (int'(ptr) + k) % NREQ;
            hit_s     = !grant_vld && req[j];
            grant[j]  = grant[j] | hit_s;
            grant_idx = hit_s ? IW'(j) : grant_idx;
            grant_vld = grant_vld | hit_s;
        end
    end
endmodule

// File: rtl/wca_reg_bank_arbiter.sv
// Config register bank with a round-robin shared write path, sequenced
// bank-wide clear and a registered read-back port.
module wca_reg_bank_arbiter
    import wca_reg_bank_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    wca_reg_bank_arbiter_if.slave  bus,
    input  logic                   clr_all,
    output logic                   clr_done,
    input  logic [AW-1:0]          rd_addr,
    output logic [REG_W-1:0]       rd_data,
    output logic [NREGS*REG_W-1:0] reg_q
);
    localparam int IW = $clog2(NREQ);
    localparam logic [AW:0] NREGS_V = (AW+1)'(NREGS);

    state_e            state_r;
    logic [IW-1:0]     ptr_r, win_r;
    logic [AW-1:0]     addr_r;
    logic [REG_W-1:0]  data_r, rd_data_r;
    logic [NREQ-1:0]   gnt_r;
    logic              clr_pend_r, addr_err_r, clr_done_r;

    logic [NREQ-1:0]   arb_gnt_s;
    logic [IW-1:0]     arb_idx_s;
    logic              arb_vld_s, aclr_s;
    logic [AW-1:0]     win_addr_s;
    logic [REG_W-1:0]  win_data_s;
    logic [REG_W-1:0]  q_s [NREGS];

    wca_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (bus.req),
        .ptr       (ptr_r),
        .grant     (arb_gnt_s),
        .grant_idx (arb_idx_s),
        .grant_vld (arb_vld_s)
    );

    assign win_addr_s = AW'(bus_slice(BUS_W'(bus.wr_addr), 32'(arb_idx_s), AW));
    assign win_data_s = bus_slice(BUS_W'(bus.wr_data), 32'(arb_idx_s), REG_W);

    // Control FSM; gnt/addr_err/clr_done are set on entry so they are high for the whole WRITE/CLEAR cycle.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            win_r      <= '0;
            addr_r     <= '0;
            data_r     <= '0;
            clr_pend_r <= 1'b0;
            gnt_r      <= '0;
            addr_err_r <= 1'b0;
            clr_done_r <= 1'b0;
        end else begin
            gnt_r      <= '0;
            addr_err_r <= 1'b0;
            clr_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (clr_all || clr_pend_r) begin
                        clr_pend_r <= 1'b0;
                        clr_done_r <= 1'b1;
                        state_r    <= ST_CLEAR;
                    end else if (arb_vld_s) begin
                        win_r      <= arb_idx_s;
                        addr_r     <= win_addr_s;
                        data_r     <= win_data_s;
                        gnt_r      <= arb_gnt_s;
                        addr_err_r <= ({1'b0, win_addr_s} >= NREGS_V);
                        state_r    <= ST_WRITE;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    clr_pend_r <= clr_pend_r | clr_all;
                    ptr_r      <= (win_r == IW'(NREQ - 1)) ? '0 : win_r + IW'(1);
                    state_r    <= ST_IDLE;
                end
                ST_CLEAR: begin
                    clr_pend_r <= clr_pend_r | clr_all;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign aclr_s = ~Reset_n | (state_r == ST_CLEAR);

    for (genvar k = 0; k < NREGS; k++) begin : g_reg
        wca_reg16_core u_core (
            .Clock  (Clock),
            .Aclr   (aclr_s),
            .Enable ((state_r == ST_WRITE) && (addr_r == AW'(k))),
            .D      (data_r),
            .Q      (q_s[k])
        );
        assign reg_q[k*REG_W +: REG_W] = q_s[k];
    end

    // Read-back: samples the bank before any same-cycle write lands.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            rd_data_r <= '0;
        end else if ({1'b0, rd_addr} < NREGS_V) begin
            rd_data_r <= q_s[rd_addr];
        end else begin
            rd_data_r <= '0;
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.addr_err = addr_err_r;
    assign clr_done     = clr_done_r;
    assign rd_data      = rd_data_r;
endmodule

// File: tb/tb_wca_reg_bank_arbiter.sv
// Scoreboard bench: a reference model predicts grants, clears and bank contents;
// a monitor compares every DUT event and the read/bank state against it.
module tb_wca_reg_bank_arbiter;
    import wca_reg_bank_arbiter_pkg::*;

    localparam int NREQ  = 4;
    localparam int NREGS = 6;
    localparam int AW    = 3;
    localparam int RW    = NREGS * REG_W;

    typedef struct {
        bit              is_clr;
        int              idx;
        bit              err;
        logic [RW-1:0]   snap;
    } exp_t;

    logic             Clock   = 1'b0;
    logic             Reset_n = 1'b0;
    logic             clr_all = 1'b0;
    logic             clr_done;
    logic [AW-1:0]    rd_addr = 3'd0;
    logic [REG_W-1:0] rd_data;
    logic [RW-1:0]    reg_q;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    wca_reg_bank_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

    wca_reg_bank_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .AW(AW)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .bus      (bus),
        .clr_all  (clr_all),
        .clr_done (clr_done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .reg_q    (reg_q)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] need);
        checks++;
        if (act !== need) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, need);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #2;
    endtask

    // Reference model: one decision per sampled clock, from the arbitration rules.
    int               m_ptr  = 0;
    bit               m_busy = 1'b0;
    bit               m_pend = 1'b0;
    logic [REG_W-1:0] m_mem [NREGS];

    task automatic push_ev(input bit is_clr, input int idx, input bit err);
        exp_t e;
        e.is_clr = is_clr;
        e.idx    = idx;
        e.err    = err;
        for (int k = 0; k < NREGS; k++) e.snap[k*REG_W +: REG_W] = m_mem[k];
        exp_q.push_back(e);
    endtask

    initial begin
        int               w;
        logic [AW-1:0]    a;
        logic [REG_W-1:0] d;
        foreach (m_mem[k]) m_mem[k] = 16'h0000;
        forever begin
            @(negedge Clock);
            if (!Reset_n) begin
                m_ptr  = 0;
                m_busy = 1'b0;
                m_pend = 1'b0;
                foreach (m_mem[k]) m_mem[k] = 16'h0000;
            end else if (m_busy) begin
                m_pend = m_pend | clr_all;
                m_busy = 1'b0;
            end else if (clr_all || m_pend) begin
                foreach (m_mem[k]) m_mem[k] = 16'h0000;
                m_pend = 1'b0;
                m_busy = 1'b1;
                push_ev(1'b1, 0, 1'b0);
            end else if (bus.req != '0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && bus.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                a = bus.wr_addr[w*AW +: AW];
                d = bus.wr_data[w*REG_W +: REG_W];
                if (int'(a) < NREGS) m_mem[a] = d;
                m_ptr  = (w + 1) % NREQ;
                m_busy = 1'b1;
                push_ev(1'b0, w, int'(a) >= NREGS);
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT shows an event.
    initial begin
        logic [RW-1:0]    vis, snap_next;
        bit               snap_due;
        logic [REG_W-1:0] exp_rd;
        logic [NREQ-1:0]  eg;
        exp_t             e;
        vis = '0; snap_next = '0; snap_due = 1'b0;
        forever begin
            @(posedge Clock);
            #1;
            if (!Reset_n) begin
                chk("rst_gnt", 128'(bus.gnt), 128'(0));
                chk("rst_clr_done", 128'(clr_done), 128'(0));
                chk("rst_addr_err", 128'(bus.addr_err), 128'(0));
                chk("rst_rd_data", 128'(rd_data), 128'(0));
                chk("rst_reg_q", 128'(reg_q), 128'(0));
                exp_q.delete();
                snap_due = 1'b0;
                vis = '0;
            end else begin
                exp_rd = (int'(rd_addr) < NREGS) ? vis[int'(rd_addr)*REG_W +: REG_W] : 16'h0000;
                chk("rd_data", 128'(rd_data), 128'(exp_rd));
                if (snap_due) begin
                    vis = snap_next;
                    snap_due = 1'b0;
                    chk("reg_q", 128'(reg_q), 128'(vis));
                end
                if (bus.gnt != '0 || clr_done || bus.addr_err) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", 128'({bus.gnt, clr_done, bus.addr_err}), 128'(0));
                    end else begin
                        e  = exp_q.pop_front();
                        eg = e.is_clr ? '0 : NREQ'(1 << e.idx);
                        chk("gnt", 128'(bus.gnt), 128'(eg));
                        chk("clr_done", 128'(clr_done), 128'(e.is_clr));
                        chk("addr_err", 128'(bus.addr_err), 128'(e.err));
                        snap_next = e.snap;
                        snap_due  = 1'b1;
                    end
                end else if (exp_q.size() != 0) begin
                    e  = exp_q.pop_front();
                    eg = e.is_clr ? '0 : NREQ'(1 << e.idx);
                    chk("missing_event", 128'({bus.gnt, clr_done, bus.addr_err}),
                        128'({eg, e.is_clr, e.err}));
                end
            end
        end
    end

    task automatic wait_gnt(input logic [NREQ-1:0] mask, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while ((bus.gnt & mask) == '0 && n < 20);
        chk("wait_gnt", 128'((bus.gnt & mask) != '0), 128'(1));
    endtask

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        int            n, t;
        int            order [4];
        int            when  [4];
        int            wait_cnt [NREQ];
        int            max_wait;
        logic [RW-1:0] expv;

        bus.req = '0; bus.wr_addr = '0; bus.wr_data = '0;
        repeat (3) cyc();
        Reset_n = 1'b1;
        cyc();

        // single write
        bus.wr_addr[0 +: AW] = 3'd3;
        bus.wr_data[0 +: REG_W] = 16'hA5A5;
        bus.req = 4'b0001;
        wait_gnt(4'b0001, n);
        chk("single_latency", 128'(n), 128'(1));
        bus.req = 4'b0000;
        cyc();
        expv = '0;
        expv[3*REG_W +: REG_W] = 16'hA5A5;
        chk("single_regs", 128'(reg_q), 128'(expv));

        // reset during the WRITE cycle aborts the write
        bus.wr_addr[1*AW +: AW] = 3'd5;
        bus.wr_data[1*REG_W +: REG_W] = 16'h1234;
        bus.req = 4'b0010;
        wait_gnt(4'b0010, n);
        Reset_n = 1'b0;
        bus.req = 4'b0000;
        cyc(); cyc();
        Reset_n = 1'b1;
        cyc();
        chk("reset_regs", 128'(reg_q), 128'(0));
        chk("reset_rd_data", 128'(rd_data), 128'(0));

        // contention from a fresh pointer
        for (int i = 0; i < NREQ; i++) begin
            bus.wr_addr[i*AW +: AW] = AW'(i);
            bus.wr_data[i*REG_W +: REG_W] = 16'h1000 + REG_W'(i);
            order[i] = -1; when[i] = 0;
        end
        bus.req = 4'b1111;
        n = 0; t = 0;
        while (n < 4 && t < 30) begin
            cyc();
            t++;
            if (bus.gnt != '0) begin
                for (int k = 0; k < NREQ; k++) if (bus.gnt[k]) order[n] = k;
                when[n] = t;
                n++;
                bus.req = bus.req & ~bus.gnt;
            end
        end
        chk("contention_count", 128'(n), 128'(4));
        for (int k = 0; k < 4; k++) chk("contention_order", 128'(order[k]), 128'(k));
        for (int k = 0; k < 3; k++) chk("contention_gap", 128'(when[k+1] - when[k]), 128'(2));
        cyc();
        expv = '0;
        for (int k = 0; k < 4; k++) expv[k*REG_W +: REG_W] = 16'h1000 + REG_W'(k);
        chk("contention_regs", 128'(reg_q), 128'(expv));

        // clear beats a simultaneous request
        bus.wr_addr[2*AW +: AW] = 3'd5;
        bus.wr_data[2*REG_W +: REG_W] = 16'hBEEF;
        bus.req = 4'b0100;
        clr_all = 1'b1;
        cyc();
        clr_all = 1'b0;
        chk("clr_first", 128'(clr_done), 128'(1));
        chk("clr_no_gnt", 128'(bus.gnt), 128'(0));
        wait_gnt(4'b0100, n);
        chk("gnt_after_clr", 128'(n), 128'(2));
        bus.req = 4'b0000;
        cyc();
        expv = '0;
        expv[5*REG_W +: REG_W] = 16'hBEEF;
        chk("clr_prio_regs", 128'(reg_q), 128'(expv));

        // clear arriving during WRITE is held pending
        bus.wr_addr[0 +: AW] = 3'd1;
        bus.wr_data[0 +: REG_W] = 16'h7777;
        bus.req = 4'b0001;
        wait_gnt(4'b0001, n);
        clr_all = 1'b1;
        bus.req = 4'b0000;
        cyc();
        clr_all = 1'b0;
        chk("pend_not_yet", 128'(clr_done), 128'(0));
        cyc();
        chk("pend_clr_done", 128'(clr_done), 128'(1));
        cyc();
        chk("pend_regs", 128'(reg_q), 128'(0));

        // out-of-range address
        bus.wr_addr[1*AW +: AW] = 3'd7;
        bus.wr_data[1*REG_W +: REG_W] = 16'hFFFF;
        bus.req = 4'b0010;
        wait_gnt(4'b0010, n);
        chk("bad_addr_err", 128'(bus.addr_err), 128'(1));
        bus.req = 4'b0000;
        rd_addr = 3'd7;
        cyc(); cyc();
        chk("bad_rd_data", 128'(rd_data), 128'(0));

        // randomized traffic
        max_wait = 0;
        foreach (wait_cnt[i]) wait_cnt[i] = 0;
        for (int c = 0; c < 2500; c++) begin
            cyc();
            Reset_n = ($urandom_range(0, 399) != 0);
            clr_all = ($urandom_range(0, 39) == 0);
            rd_addr = AW'($urandom_range(0, 7));
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req[i]) wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                if (bus.gnt[i] || !bus.req[i]) begin
                    wait_cnt[i] = 0;
                    if ($urandom_range(0, 3) < (bus.gnt[i] ? 2 : 1)) begin
                        bus.req[i] = 1'b1;
                        bus.wr_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                        bus.wr_data[i*REG_W +: REG_W] = REG_W'($urandom);
                    end else begin
                        bus.req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    bus.req[i] = 1'b0;
                    wait_cnt[i] = 0;
                end
            end
        end
        bus.req = '0; clr_all = 1'b0; Reset_n = 1'b1;
        repeat (6) cyc();
        chk("max_wait_bound", 128'(max_wait < 60), 128'(1));
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
